// File: rtl/exc_vector_fetch_if.sv
// Signal bundle between the exception vector fetch sequencer and its datapath.
// The slave modport is the sequencer; the master modport is the datapath side.
interface exc_vector_fetch_if;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;
    logic [2:0]  srcaddr_sel;
    logic [31:0] epc_out;
    logic        epc_wr;
    logic [31:0] pc_out;
    logic        pc_wr;
    logic [1:0]  exc_cause;
    logic        busy;
    logic        done;

    modport master (
        output exc_opcode, exc_overflow, exc_div0, pc_in, mem_data_in,
        input  srcaddr_sel, epc_out, epc_wr, pc_out, pc_wr, exc_cause, busy, done
    );

    modport slave (
        input  exc_opcode, exc_overflow, exc_div0, pc_in, mem_data_in,
        output srcaddr_sel, epc_out, epc_wr, pc_out, pc_wr, exc_cause, busy, done
    );
endinterface

// File: rtl/exc_vector_fetch.sv
// Exception entry sequencer: saves EPC, reads the vector byte from address
// 253/254/255 by cause, loads it into the PC, then pulses done.
//
// state | meaning
// IDLE  | waiting for any exc_* request
// SAVE  | EPC write of pc_in - 4
// ADDR  | vector address driven for MEM_WAIT+1 cycles
// LOAD  | PC write of the fetched vector byte
// DONE  | one-cycle completion pulse
module exc_vector_fetch #(
    parameter int MEM_WAIT = 1
) (
    input  logic clk,
    input  logic reset,
    exc_vector_fetch_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SAVE = 3'd1,
        ADDR = 3'd2,
        LOAD = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [2:0]  srcaddr_sel;
    logic [31:0] epc_out;
    logic        epc_wr;
    logic [31:0] pc_out;
    logic        pc_wr;
    logic [1:0]  exc_cause;
    logic        busy;
    logic        done;

    logic        any_req;
    logic [1:0]  win_cause;
    logic        unused_ok;

    assign any_req = bus.exc_opcode | bus.exc_overflow | bus.exc_div0;

    // Fixed priority: opcode over overflow over divide-by-zero.
    always_comb begin
        win_cause = 2'b00;
        if (bus.exc_opcode)
            win_cause = 2'b01;
        else if (bus.exc_overflow)
            win_cause = 2'b10;
        else if (bus.exc_div0)
            win_cause = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 3'd0;
            srcaddr_sel <= 3'b000;
            epc_out     <= 32'd0;
            epc_wr      <= 1'b0;
            pc_out      <= 32'd0;
            pc_wr       <= 1'b0;
            exc_cause   <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            epc_wr <= 1'b0;
            pc_wr  <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= SAVE;
                        exc_cause <= win_cause;
                        epc_out   <= bus.pc_in - 32'd4;
                        epc_wr    <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SAVE: begin
                    state       <= ADDR;
                    wait_cnt    <= WAIT_LOAD;
                    // Cause code 01/10/11 maps directly onto selects 001/010/011.
                    srcaddr_sel <= {1'b0, exc_cause};
                end
                ADDR: begin
                    if (wait_cnt == 3'd0) begin
                        state       <= LOAD;
                        pc_out      <= {24'd0, bus.mem_data_in[7:0]};
                        pc_wr       <= 1'b1;
                        srcaddr_sel <= 3'b000;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                LOAD: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    srcaddr_sel <= 3'b000;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Only the low byte of the memory word carries the vector.
    assign unused_ok = ^bus.mem_data_in[31:8];

    assign bus.srcaddr_sel = srcaddr_sel;
    assign bus.epc_out     = epc_out;
    assign bus.epc_wr      = epc_wr;
    assign bus.pc_out      = pc_out;
    assign bus.pc_wr       = pc_wr;
    assign bus.exc_cause   = exc_cause;
    assign bus.busy        = busy;
    assign bus.done        = done;

endmodule

// File: tb/tb_exc_vector_fetch.sv
// Directed bench for exc_vector_fetch; three instances (MEM_WAIT 0/1/3) share
// one stimulus, the MEM_WAIT=1 instance carries most checks.
module tb_exc_vector_fetch;

    logic        clk;
    logic        reset;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;

    int n_assert;
    int n_fail;

    exc_vector_fetch_if bus0 ();
    exc_vector_fetch_if bus1 ();
    exc_vector_fetch_if bus3 ();

    assign bus0.exc_opcode = exc_opcode;   assign bus1.exc_opcode = exc_opcode;   assign bus3.exc_opcode = exc_opcode;
    assign bus0.exc_overflow = exc_overflow; assign bus1.exc_overflow = exc_overflow; assign bus3.exc_overflow = exc_overflow;
    assign bus0.exc_div0 = exc_div0;       assign bus1.exc_div0 = exc_div0;       assign bus3.exc_div0 = exc_div0;
    assign bus0.pc_in = pc_in;             assign bus1.pc_in = pc_in;             assign bus3.pc_in = pc_in;
    assign bus0.mem_data_in = mem_data_in; assign bus1.mem_data_in = mem_data_in; assign bus3.mem_data_in = mem_data_in;

    exc_vector_fetch #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    exc_vector_fetch #(.MEM_WAIT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    exc_vector_fetch #(.MEM_WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling happens on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int pcwr0_cyc, pcwr1_cyc, pcwr3_cyc;
        logic [31:0] pcout0, pcout3;
        logic pcwr_seen;

        n_assert = 0;
        n_fail = 0;
        reset = 1'b1;
        exc_opcode = 1'b0;
        exc_overflow = 1'b0;
        exc_div0 = 1'b0;
        pc_in = 32'd0;
        mem_data_in = 32'd0;

        // Reset state
        idle(2);
        chk("rst_sel", {29'd0, bus1.srcaddr_sel}, 32'd0);
        chk("rst_epc_out", bus1.epc_out, 32'd0);
        chk("rst_pc_out", bus1.pc_out, 32'd0);
        chk("rst_cause", {30'd0, bus1.exc_cause}, 32'd0);
        chk("rst_strobes", {28'd0, bus1.epc_wr, bus1.pc_wr, bus1.busy, bus1.done}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Overflow, pc_in 0x10, vector 0xA5
        pc_in = 32'h0000_0010;
        mem_data_in = 32'h0000_00A5;
        exc_overflow = 1'b1;
        step();
        exc_overflow = 1'b0;
        chk("t1_c1_epc_wr", {31'd0, bus1.epc_wr}, 32'd1);
        chk("t1_c1_epc_out", bus1.epc_out, 32'h0000_000C);
        chk("t1_c1_cause", {30'd0, bus1.exc_cause}, 32'd2);
        chk("t1_c1_busy_sel", {28'd0, bus1.busy, bus1.srcaddr_sel}, 32'h8);
        step();
        chk("t1_c2_sel", {29'd0, bus1.srcaddr_sel}, 32'd2);
        chk("t1_c2_epc_wr", {31'd0, bus1.epc_wr}, 32'd0);
        step();
        chk("t1_c3_sel", {29'd0, bus1.srcaddr_sel}, 32'd2);
        chk("t1_c3_pc_wr", {31'd0, bus1.pc_wr}, 32'd0);
        step();
        chk("t1_c4_pc_wr", {31'd0, bus1.pc_wr}, 32'd1);
        chk("t1_c4_pc_out", bus1.pc_out, 32'h0000_00A5);
        chk("t1_c4_sel", {29'd0, bus1.srcaddr_sel}, 32'd0);
        step();
        chk("t1_c5_done_busy_pcwr", {29'd0, bus1.done, bus1.busy, bus1.pc_wr}, 32'b110);
        step();
        chk("t1_c6_done_busy", {30'd0, bus1.done, bus1.busy}, 32'd0);
        chk("t1_c6_cause_hold", {30'd0, bus1.exc_cause}, 32'd2);
        idle(4);

        // All three requests together: opcode wins, one sequence only
        pc_in = 32'h0000_0100;
        exc_opcode = 1'b1;
        exc_overflow = 1'b1;
        exc_div0 = 1'b1;
        step();
        exc_opcode = 1'b0;
        exc_overflow = 1'b0;
        exc_div0 = 1'b0;
        chk("t2_c1_cause", {30'd0, bus1.exc_cause}, 32'd1);
        chk("t2_c1_epc_out", bus1.epc_out, 32'h0000_00FC);
        step();
        chk("t2_c2_sel", {29'd0, bus1.srcaddr_sel}, 32'd1);
        idle(3);
        chk("t2_c5_done", {31'd0, bus1.done}, 32'd1);
        idle(2);
        chk("t2_c7_no_restart", {30'd0, bus1.busy, bus1.epc_wr}, 32'd0);
        idle(3);

        // Divide-by-zero with pc_in 0: EPC wraps
        pc_in = 32'h0000_0000;
        exc_div0 = 1'b1;
        step();
        exc_div0 = 1'b0;
        chk("t3_c1_epc_out", bus1.epc_out, 32'hFFFF_FFFC);
        chk("t3_c1_cause", {30'd0, bus1.exc_cause}, 32'd3);
        step();
        chk("t3_c2_sel", {29'd0, bus1.srcaddr_sel}, 32'd3);
        idle(7);

        // Opcode re-raised during ADDR is ignored
        pc_in = 32'h0000_0040;
        mem_data_in = 32'h0000_0033;
        exc_opcode = 1'b1;
        step();
        exc_opcode = 1'b0;
        step();
        exc_opcode = 1'b1;
        step();
        exc_opcode = 1'b0;
        step();
        chk("t4_c4_pc_wr", {31'd0, bus1.pc_wr}, 32'd1);
        chk("t4_c4_pc_out", bus1.pc_out, 32'h0000_0033);
        step();
        chk("t4_c5_done", {31'd0, bus1.done}, 32'd1);
        idle(2);
        chk("t4_c7_no_restart", {30'd0, bus1.busy, bus1.epc_wr}, 32'd0);
        idle(4);

        // Request held through the whole sequence restarts once back in IDLE
        pc_in = 32'h0000_0200;
        exc_overflow = 1'b1;
        idle(6);
        chk("t5_c6_idle_gap", {31'd0, bus1.busy}, 32'd0);
        step();
        chk("t5_c7_restart", {30'd0, bus1.epc_wr, bus1.busy}, 32'b11);
        exc_overflow = 1'b0;
        idle(10);

        // Reset during ADDR aborts; reset beats a simultaneous request
        pc_in = 32'h0000_0020;
        exc_overflow = 1'b1;
        step();
        exc_overflow = 1'b0;
        step();
        chk("t6_c2_in_addr", {29'd0, bus1.srcaddr_sel}, 32'd2);
        reset = 1'b1;
        exc_opcode = 1'b1;
        step();
        chk("t6_rst_busy_sel", {28'd0, bus1.busy, bus1.srcaddr_sel}, 32'd0);
        chk("t6_rst_cause", {30'd0, bus1.exc_cause}, 32'd0);
        chk("t6_rst_epc_wr", {31'd0, bus1.epc_wr}, 32'd0);
        reset = 1'b0;
        exc_opcode = 1'b0;
        pcwr_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus1.pc_wr === 1'b1) pcwr_seen = 1'b1;
        end
        chk("t6_no_pc_wr", {31'd0, pcwr_seen}, 32'd0);

        // MEM_WAIT 0 / 1 / 3 latency with vector 0x7E
        pc_in = 32'h0000_0080;
        mem_data_in = 32'hFFFF_FF7E;
        exc_div0 = 1'b1;
        pcwr0_cyc = 0;
        pcwr1_cyc = 0;
        pcwr3_cyc = 0;
        pcout0 = 32'd0;
        pcout3 = 32'd0;
        for (int c = 1; c <= 10; c++) begin
            step();
            exc_div0 = 1'b0;
            if (bus0.pc_wr === 1'b1 && pcwr0_cyc == 0) begin pcwr0_cyc = c; pcout0 = bus0.pc_out; end
            if (bus1.pc_wr === 1'b1 && pcwr1_cyc == 0) pcwr1_cyc = c;
            if (bus3.pc_wr === 1'b1 && pcwr3_cyc == 0) begin pcwr3_cyc = c; pcout3 = bus3.pc_out; end
        end
        chk("t7_mw0_pc_wr_cycle", pcwr0_cyc, 32'd3);
        chk("t7_mw1_pc_wr_cycle", pcwr1_cyc, 32'd4);
        chk("t7_mw3_pc_wr_cycle", pcwr3_cyc, 32'd6);
        chk("t7_mw0_pc_out", pcout0, 32'h0000_007E);
        chk("t7_mw3_pc_out", pcout3, 32'h0000_007E);
        chk("t7_all_idle", {29'd0, bus0.busy, bus1.busy, bus3.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_vector_fetch.md
EXC_VECTOR_FETCH -- requirements
Module: exc_vector_fetch

Interface
REQ-001 Parameter MEM_WAIT, default 1, meaning: number of cycles, counted after the first address cycle, before the memory read data is sampled (legal range 0..7).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 exc_opcode  input  1  invalid-opcode exception request, level.
REQ-005 exc_overflow  input  1  arithmetic-overflow exception request, level.
REQ-006 exc_div0  input  1  divide-by-zero exception request, level.
REQ-007 pc_in  input  32  current PC value, already incremented past the faulting instruction.
REQ-008 mem_data_in  input  32  memory read data; the vector byte is mem_data_in[7:0].
REQ-009 srcaddr_sel  output  3  select code for the memory address source mux: 000 = IorD path, 001 = address 253, 010 = address 254, 011 = address 255.
REQ-010 epc_out / epc_wr  output  32 / 1  EPC write data and one-cycle write strobe.
REQ-011 pc_out / pc_wr  output  32 / 1  new PC write data and one-cycle write strobe.
REQ-012 exc_cause  output  2  latched cause: 01 opcode, 10 overflow, 11 div0, 00 none.
REQ-013 busy / done  output  1 / 1  sequence in progress / one-cycle completion pulse.

Function
REQ-014 The block SHALL implement FSM states IDLE, SAVE, ADDR, LOAD, DONE; all outputs registered.
REQ-015 In IDLE, a request is sampled on any rising edge where at least one exc_* input is high; the FSM moves to SAVE.
REQ-016 Priority on simultaneous requests: opcode > overflow > div0; only the winner is latched into exc_cause.
REQ-017 SAVE (1 cycle): epc_out = pc_in - 4, modulo 2^32 (pc_in 0 -> FFFF_FFFC); epc_wr = 1; pc_in is sampled on the edge that enters SAVE.
REQ-018 ADDR (MEM_WAIT+1 cycles, counted by an internal 3-bit counter): srcaddr_sel = 001/010/011 for cause opcode/overflow/div0.
REQ-019 mem_data_in[7:0] SHALL be captured on the final ADDR cycle's closing edge.
REQ-020 LOAD (1 cycle): pc_out = {24'b0, captured byte}; pc_wr = 1; srcaddr_sel = 000.
REQ-021 DONE (1 cycle): done = 1; then return to IDLE.
REQ-022 busy = 1 in SAVE, ADDR, LOAD, DONE; 0 in IDLE.
REQ-023 Outside ADDR, srcaddr_sel = 000; epc_wr and pc_wr are 0 outside SAVE and LOAD respectively.
REQ-024 exc_* inputs are ignored while busy; a request still high in IDLE after DONE starts a new sequence.
REQ-025 Total latency, counted from the request edge: epc_wr in cycle 1, address cycles 2..2+MEM_WAIT, pc_wr in cycle 3+MEM_WAIT, done in cycle 4+MEM_WAIT.
REQ-026 exc_cause holds its value from SAVE until the next accepted request or reset.

Reset
REQ-027 With reset high at a rising edge, the FSM SHALL go to IDLE and clear the counter.
REQ-028 The same reset SHALL set srcaddr_sel = 000, epc_out = 0, pc_out = 0, exc_cause = 00, and deassert epc_wr, pc_wr, busy and done.
REQ-029 Reset mid-sequence SHALL abort with no further epc_wr/pc_wr strobes; reset takes precedence over any exc_* input on the same edge.

Verification
REQ-030 MEM_WAIT=1, pc_in=0x0000_0010, exc_overflow pulse, mem_data_in=0x0000_00A5 -> epc_wr cycle 1 with 0x0000_000C; sel=010 cycles 2-3; pc_wr cycle 4 with 0x0000_00A5; done cycle 5.
REQ-031 All three exc_* high together -> exc_cause=01, sel=001, only one sequence runs.
REQ-032 pc_in=0, exc_div0 -> epc_out=0xFFFF_FFFC, sel=011, exc_cause=11.
REQ-033 exc_opcode asserted again during ADDR -> ignored; after the request drops, no second sequence starts.
REQ-034 Reset asserted in ADDR -> next cycle: IDLE, sel=000, busy=0, no pc_wr ever seen.
REQ-035 MEM_WAIT=0 and MEM_WAIT=3, mem_data_in=0xFFFF_FF7E -> pc_out=0x0000_007E; pc_wr at cycles 3 and 6 respectively.
